// File: rtl/fpu_pkg.sv
// Shared FPU scheduling types: data widths, op codes, tag payload and scheduler FSM states.
package fpu_pkg;

  localparam int unsigned FPU_W     = 32;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned TAG_IDX_W = 3;
  localparam int unsigned CNT_W     = 16;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV = 4'b0011;

  // Owner tag carried alongside each in-flight op; idx sized for up to 8 requesters.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } sched_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (with wrap) wins a one-hot grant.
module rr_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  grant_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             grant_any_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    grant_any_c = 1'b0;
    cand        = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = IDX_W'((32'(ptr) + off) % NREQ);
      if (en && !grant_any_c && req[cand]) begin
        grant_any_c    = 1'b1;
        grant_c[cand]  = 1'b1;
        grant_idx_c    = cand;
      end
    end
  end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Round-robin sharing of one fixed-latency fpu_top among NREQ requesters, with owner-tagged responses.
// Optional per-requester grant counters on issue_cnt when FPU_SCHED_STATS_EN is defined.
module fpu_rr_scheduler
  import fpu_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned FPU_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [FPU_W*NREQ-1:0]  req_num1,
  input  logic [FPU_W*NREQ-1:0]  req_num2,
  input  logic [OP_W*NREQ-1:0]   req_op,
  output logic [FPU_W-1:0]       fpu_num1,
  output logic [FPU_W-1:0]       fpu_num2,
  output logic [OP_W-1:0]        fpu_op,
  input  logic [FPU_W-1:0]       fpu_result,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [FPU_W-1:0]       rsp_result,
  input  logic                   drain,
  output logic                   idle
`ifdef FPU_SCHED_STATS_EN
  ,
  output logic [CNT_W*NREQ-1:0]  issue_cnt
`endif
);

  localparam int unsigned IDX_W = idx_width(NREQ);

  sched_state_e     state;
  sched_state_e     state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  // Stage 0 is loaded with the operand registers; fpu_result lines up with stage FPU_LAT.
  tag_t             tags [FPU_LAT+1];

  logic             grant_en_c;
  logic             grant_any_c;
  logic [NREQ-1:0]  grant_c;
  logic [IDX_W-1:0] grant_idx_c;
  logic             pipe_busy_c;
  logic [FPU_W-1:0] sel_num1_c;
  logic [FPU_W-1:0] sel_num2_c;
  logic [OP_W-1:0]  sel_op_c;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .en          (grant_en_c),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .grant_any_c (grant_any_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:     if (drain) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain)           state_nxt = ST_RUN;
        else if (!pipe_busy_c) state_nxt = ST_DRAINED;
      end
      ST_DRAINED: if (!drain) state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    grant_en_c = 1'b0;
    idle       = 1'b0;
    grant_en_c = (state == ST_RUN) && !drain;
    idle       = (state == ST_DRAINED);
  end

  assign req_ready = grant_c;

  always_comb begin
    pipe_busy_c = 1'b0;
    for (int unsigned i = 0; i <= FPU_LAT; i++) pipe_busy_c = pipe_busy_c | tags[i].valid;
  end

  // One-hot grant selects the winning requester's operand slot.
  always_comb begin
    sel_num1_c = '0;
    sel_num2_c = '0;
    sel_op_c   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        sel_num1_c = sel_num1_c | req_num1[i*FPU_W +: FPU_W];
        sel_num2_c = sel_num2_c | req_num2[i*FPU_W +: FPU_W];
        sel_op_c   = sel_op_c   | req_op[i*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_num1   <= '0;
      fpu_num2   <= '0;
      fpu_op     <= '0;
      rr_ptr     <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      for (int unsigned i = 0; i <= FPU_LAT; i++) tags[i] <= '0;
    end else begin
      if (grant_any_c) begin
        fpu_num1 <= sel_num1_c;
        fpu_num2 <= sel_num2_c;
        fpu_op   <= sel_op_c;
        rr_ptr   <= (grant_idx_c == IDX_W'(NREQ - 1)) ? '0 : IDX_W'(grant_idx_c + 1'b1);
      end
      tags[0] <= '{valid: grant_any_c, idx: TAG_IDX_W'(grant_idx_c)};
      for (int unsigned i = 1; i <= FPU_LAT; i++) tags[i] <= tags[i-1];
      rsp_valid <= '0;
      if (tags[FPU_LAT].valid) begin
        rsp_valid  <= NREQ'(1) << tags[FPU_LAT].idx;
        rsp_result <= fpu_result;
      end
    end
  end

`ifdef FPU_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++)
        if (grant_c[i] && (cnt_q[i] != '1)) cnt_q[i] <= CNT_W'(cnt_q[i] + 1'b1);
    end
  end

  always_comb begin
    issue_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) issue_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule
